// File: rtl/spu_pkg.sv
// rtl/spu_pkg.sv - shared widths, unit encodings and retire-slot record for the SPU writeback slice
package spu_pkg;

  localparam int DATA_W   = 128;
  localparam int RADDR_W  = 7;
  localparam int NUM_REGS = 128;
  localparam int CHK_SLOTS = 4;

  typedef enum logic [2:0] {
    UNIT_SP   = 3'd0,
    UNIT_FX2  = 3'd1,
    UNIT_BYTE = 3'd2,
    UNIT_FX1  = 3'd3,
    UNIT_FP   = 3'd4,
    UNIT_LS   = 3'd5,
    UNIT_PERM = 3'd6,
    UNIT_BR   = 3'd7
  } unit_e;

  typedef struct packed {
    logic               we;
    logic [RADDR_W-1:0] rt;
    logic [DATA_W-1:0]  data;
    logic [2:0]         unit;
    logic [2:0]         latency;
  } retire_slot_t;

  // One-hot register mask, all zero when en is low.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic en, input logic [RADDR_W-1:0] idx);
    reg_onehot      = '0;
    reg_onehot[idx] = en;
  endfunction

endpackage

// File: rtl/spu_writeback_if.sv
// rtl/spu_writeback_if.sv - retire/issue/lookup/rf-write bundle; forwarding signals exist only with SPU_WB_FORWARD_EN
interface spu_writeback_if;
  import spu_pkg::*;

  logic                       regWriteEnable_in1, regWriteEnable_in2;
  logic [DATA_W-1:0]          result_in1, result_in2;
  logic [RADDR_W-1:0]         readRegisterRT_in1, readRegisterRT_in2;
  logic [2:0]                 unitID_in1, unitID_in2;
  logic [2:0]                 latency_in1, latency_in2;
  logic                       issue_valid_in1, issue_valid_in2;
  logic [RADDR_W-1:0]         issue_rt_in1, issue_rt_in2;
  logic [CHK_SLOTS*RADDR_W-1:0] chk_reg_in;
  logic [CHK_SLOTS-1:0]       chk_busy_out;
  logic                       rf_we_out1, rf_we_out2;
  logic [RADDR_W-1:0]         rf_waddr_out1, rf_waddr_out2;
  logic [DATA_W-1:0]          rf_wdata_out1, rf_wdata_out2;
  logic [15:0]                collision_count_out;
  logic                       latency_err_out;
  logic [2:0]                 err_unit_out;
`ifdef SPU_WB_FORWARD_EN
  logic [CHK_SLOTS-1:0]       fwd_hit_out;
  logic [CHK_SLOTS*DATA_W-1:0] fwd_data_out;

  modport master (
    output regWriteEnable_in1, regWriteEnable_in2, result_in1, result_in2,
           readRegisterRT_in1, readRegisterRT_in2, unitID_in1, unitID_in2,
           latency_in1, latency_in2, issue_valid_in1, issue_valid_in2,
           issue_rt_in1, issue_rt_in2, chk_reg_in,
    input  chk_busy_out, rf_we_out1, rf_we_out2, rf_waddr_out1, rf_waddr_out2,
           rf_wdata_out1, rf_wdata_out2, collision_count_out, latency_err_out,
           err_unit_out, fwd_hit_out, fwd_data_out
  );
  modport slave (
    input  regWriteEnable_in1, regWriteEnable_in2, result_in1, result_in2,
           readRegisterRT_in1, readRegisterRT_in2, unitID_in1, unitID_in2,
           latency_in1, latency_in2, issue_valid_in1, issue_valid_in2,
           issue_rt_in1, issue_rt_in2, chk_reg_in,
    output chk_busy_out, rf_we_out1, rf_we_out2, rf_waddr_out1, rf_waddr_out2,
           rf_wdata_out1, rf_wdata_out2, collision_count_out, latency_err_out,
           err_unit_out, fwd_hit_out, fwd_data_out
  );
`else
  modport master (
    output regWriteEnable_in1, regWriteEnable_in2, result_in1, result_in2,
           readRegisterRT_in1, readRegisterRT_in2, unitID_in1, unitID_in2,
           latency_in1, latency_in2, issue_valid_in1, issue_valid_in2,
           issue_rt_in1, issue_rt_in2, chk_reg_in,
    input  chk_busy_out, rf_we_out1, rf_we_out2, rf_waddr_out1, rf_waddr_out2,
           rf_wdata_out1, rf_wdata_out2, collision_count_out, latency_err_out,
           err_unit_out
  );
  modport slave (
    input  regWriteEnable_in1, regWriteEnable_in2, result_in1, result_in2,
           readRegisterRT_in1, readRegisterRT_in2, unitID_in1, unitID_in2,
           latency_in1, latency_in2, issue_valid_in1, issue_valid_in2,
           issue_rt_in1, issue_rt_in2, chk_reg_in,
    output chk_busy_out, rf_we_out1, rf_we_out2, rf_waddr_out1, rf_waddr_out2,
           rf_wdata_out1, rf_wdata_out2, collision_count_out, latency_err_out,
           err_unit_out
  );
`endif

endinterface

// File: rtl/spu_scoreboard.sv
// rtl/spu_scoreboard.sv - pending-destination bit per register with four lookup ports
module spu_scoreboard
  import spu_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REGS-1:0]          set_vec,
  input  logic [NUM_REGS-1:0]          clr_vec,
  input  logic [CHK_SLOTS*RADDR_W-1:0] chk_reg,
  output logic [CHK_SLOTS-1:0]         chk_busy
);

  logic [NUM_REGS-1:0] pending;

  // Clear committed writes, then set new issues so a same-edge set wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= (pending & ~clr_vec) | set_vec;
  end

  // Look up the four queried registers.
  always_comb begin
    chk_busy = '0;
    for (int k = 0; k < CHK_SLOTS; k++)
      chk_busy[k] = pending[chk_reg[k*RADDR_W +: RADDR_W]];
  end

endmodule

// File: rtl/spu_writeback.sv
// rtl/spu_writeback.sv - retire/collision/rf write/error capture; SPU_WB_FORWARD_EN adds rf-write forwarding to lookups
module spu_writeback
  import spu_pkg::*;
(
  input logic            clk,
  input logic            reset,
  spu_writeback_if.slave wb
);

  retire_slot_t        slot1, slot2;
  logic                ret1, ret2, collide, wr1, wr2, lerr1, lerr2;
  logic [NUM_REGS-1:0] set_vec, clr_vec;
  logic [CHK_SLOTS-1:0] sb_busy;

  assign slot1 = '{we: wb.regWriteEnable_in1, rt: wb.readRegisterRT_in1, data: wb.result_in1,
                   unit: wb.unitID_in1, latency: wb.latency_in1};
  assign slot2 = '{we: wb.regWriteEnable_in2, rt: wb.readRegisterRT_in2, data: wb.result_in2,
                   unit: wb.unitID_in2, latency: wb.latency_in2};

  assign ret1    = slot1.we && (slot1.latency == 3'd0);
  assign ret2    = slot2.we && (slot2.latency == 3'd0);
  assign lerr1   = slot1.we && (slot1.latency != 3'd0);
  assign lerr2   = slot2.we && (slot2.latency != 3'd0);
  // The odd pipe is younger in program order, so its value survives a same-target retire.
  assign collide = ret1 && ret2 && (slot1.rt == slot2.rt);
  assign wr1     = ret1 && !collide;
  assign wr2     = ret2;

  // Register the qualified retires as the register-file write ports.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb.rf_we_out1    <= 1'b0;
      wb.rf_we_out2    <= 1'b0;
      wb.rf_waddr_out1 <= '0;
      wb.rf_waddr_out2 <= '0;
      wb.rf_wdata_out1 <= '0;
      wb.rf_wdata_out2 <= '0;
    end else begin
      wb.rf_we_out1    <= wr1;
      wb.rf_we_out2    <= wr2;
      wb.rf_waddr_out1 <= wr1 ? slot1.rt : '0;
      wb.rf_waddr_out2 <= wr2 ? slot2.rt : '0;
      wb.rf_wdata_out1 <= wr1 ? slot1.data : '0;
      wb.rf_wdata_out2 <= wr2 ? slot2.data : '0;
    end
  end

  // Saturating count of suppressed pipe-1 writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      wb.collision_count_out <= '0;
    else if (collide && (wb.collision_count_out != 16'hFFFF))
      wb.collision_count_out <= wb.collision_count_out + 16'd1;
  end

  // Capture the first latency error only; pipe 1 is reported when both hit together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb.latency_err_out <= 1'b0;
      wb.err_unit_out    <= '0;
    end else if (!wb.latency_err_out && (lerr1 || lerr2)) begin
      wb.latency_err_out <= 1'b1;
      wb.err_unit_out    <= lerr1 ? slot1.unit : slot2.unit;
    end
  end

  assign set_vec = reg_onehot(wb.issue_valid_in1, wb.issue_rt_in1)
                 | reg_onehot(wb.issue_valid_in2, wb.issue_rt_in2);
  assign clr_vec = reg_onehot(wb.rf_we_out1, wb.rf_waddr_out1)
                 | reg_onehot(wb.rf_we_out2, wb.rf_waddr_out2);

  spu_scoreboard u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_vec  (set_vec),
    .clr_vec  (clr_vec),
    .chk_reg  (wb.chk_reg_in),
    .chk_busy (sb_busy)
  );

`ifdef SPU_WB_FORWARD_EN
  // Match each lookup slot against the in-flight rf writes; pipe 2 takes priority.
  always_comb begin
    wb.fwd_hit_out  = '0;
    wb.fwd_data_out = '0;
    for (int k = 0; k < CHK_SLOTS; k++) begin
      if (wb.rf_we_out2 && (wb.rf_waddr_out2 == wb.chk_reg_in[k*RADDR_W +: RADDR_W])) begin
        wb.fwd_hit_out[k]                  = 1'b1;
        wb.fwd_data_out[k*DATA_W +: DATA_W] = wb.rf_wdata_out2;
      end else if (wb.rf_we_out1 && (wb.rf_waddr_out1 == wb.chk_reg_in[k*RADDR_W +: RADDR_W])) begin
        wb.fwd_hit_out[k]                  = 1'b1;
        wb.fwd_data_out[k*DATA_W +: DATA_W] = wb.rf_wdata_out1;
      end
    end
  end

  assign wb.chk_busy_out = sb_busy & ~wb.fwd_hit_out;
`else
  assign wb.chk_busy_out = sb_busy;
`endif

endmodule

// File: tb/tb_spu_writeback.sv
// tb/tb_spu_writeback.sv - self-checking bench for spu_writeback
module tb_spu_writeback;
  import spu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spu_writeback_if bus ();
  spu_writeback dut (.clk(clk), .reset(reset), .wb(bus));

  typedef struct {
    logic         we1;
    logic [6:0]   rt1;
    logic [127:0] d1;
    logic         we2;
    logic [6:0]   rt2;
    logic [127:0] d2;
    logic         exp_we1;
    logic         exp_we2;
  } vec_t;

  typedef struct {
    logic         we1;
    logic [6:0]   a1;
    logic [127:0] d1;
    logic         we2;
    logic [6:0]   a2;
    logic [127:0] d2;
    logic [15:0]  coll;
  } exp_t;

  exp_t        exp_q[$];
  vec_t        vecs[8];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] coll_model = 16'd0;
  logic        fwd_on;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.regWriteEnable_in1 = 0; bus.regWriteEnable_in2 = 0;
    bus.result_in1 = '0;        bus.result_in2 = '0;
    bus.readRegisterRT_in1 = '0; bus.readRegisterRT_in2 = '0;
    bus.unitID_in1 = '0;        bus.unitID_in2 = '0;
    bus.latency_in1 = '0;       bus.latency_in2 = '0;
    bus.issue_valid_in1 = 0;    bus.issue_valid_in2 = 0;
    bus.issue_rt_in1 = '0;      bus.issue_rt_in2 = '0;
  endtask

  task automatic set_chk(input int k, input logic [6:0] r);
    bus.chk_reg_in[k*7 +: 7] = r;
  endtask

  task automatic retire(input logic we1, input logic [6:0] rt1, input logic [127:0] d1,
                        input logic we2, input logic [6:0] rt2, input logic [127:0] d2);
    bus.regWriteEnable_in1 = we1; bus.readRegisterRT_in1 = rt1; bus.result_in1 = d1; bus.latency_in1 = 3'd0;
    bus.regWriteEnable_in2 = we2; bus.readRegisterRT_in2 = rt2; bus.result_in2 = d2; bus.latency_in2 = 3'd0;
  endtask

  task automatic pop_check(input int idx);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL vec%0d_queue: got empty expected entry", idx);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("vec%0d_we1", idx), {127'd0, bus.rf_we_out1}, {127'd0, e.we1});
      check($sformatf("vec%0d_we2", idx), {127'd0, bus.rf_we_out2}, {127'd0, e.we2});
      if (e.we1) begin
        check($sformatf("vec%0d_waddr1", idx), {121'd0, bus.rf_waddr_out1}, {121'd0, e.a1});
        check($sformatf("vec%0d_wdata1", idx), bus.rf_wdata_out1, e.d1);
      end
      if (e.we2) begin
        check($sformatf("vec%0d_waddr2", idx), {121'd0, bus.rf_waddr_out2}, {121'd0, e.a2});
        check($sformatf("vec%0d_wdata2", idx), bus.rf_wdata_out2, e.d2);
      end
      check($sformatf("vec%0d_coll", idx), {112'd0, bus.collision_count_out}, {112'd0, e.coll});
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef SPU_WB_FORWARD_EN
    fwd_on = 1'b1;
`else
    fwd_on = 1'b0;
`endif
    vecs[0] = '{1'b1, 7'd5,  {16{8'hA5}}, 1'b0, 7'd0,   128'd0,        1'b1, 1'b0};
    vecs[1] = '{1'b1, 7'd3,  {8{16'h1111}}, 1'b1, 7'd4, {8{16'h2222}}, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 7'd1,  128'h9,      1'b0, 7'd2,   128'h8,        1'b0, 1'b0};
    vecs[3] = '{1'b1, 7'd20, 128'h33,     1'b0, 7'd20,  128'h44,       1'b1, 1'b0};
    vecs[4] = '{1'b1, 7'd20, 128'h1,      1'b1, 7'd20,  128'h2,        1'b0, 1'b1};
    vecs[5] = '{1'b0, 7'd0,  128'h5,      1'b1, 7'd127, {128{1'b1}},   1'b0, 1'b1};
    vecs[6] = '{1'b1, 7'd0,  128'hDEAD,   1'b1, 7'd0,   128'hBEEF,     1'b0, 1'b1};
    vecs[7] = '{1'b1, 7'd0,  128'h77,     1'b1, 7'd127, 128'h88,       1'b1, 1'b1};

    // Reset with active inputs
    reset = 1'b0;
    idle_inputs();
    bus.chk_reg_in = '0;
    retire(1'b1, 7'd5, {16{8'hA5}}, 1'b1, 7'd6, 128'h6);
    bus.issue_valid_in1 = 1'b1; bus.issue_rt_in1 = 7'd9;
    set_chk(0, 7'd9);
    tick(); tick();
    check("rst_we1",   {127'd0, bus.rf_we_out1}, 128'd0);
    check("rst_we2",   {127'd0, bus.rf_we_out2}, 128'd0);
    check("rst_waddr1", {121'd0, bus.rf_waddr_out1}, 128'd0);
    check("rst_wdata1", bus.rf_wdata_out1, 128'd0);
    check("rst_coll",  {112'd0, bus.collision_count_out}, 128'd0);
    check("rst_lerr",  {127'd0, bus.latency_err_out}, 128'd0);
    check("rst_eunit", {125'd0, bus.err_unit_out}, 128'd0);
    check("rst_busy",  {124'd0, bus.chk_busy_out}, 128'd0);
    idle_inputs();
    bus.chk_reg_in = '0;
    reset = 1'b1;
    tick();

    // Table-driven retire vectors through the scoreboard queue
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      retire(vecs[i].we1, vecs[i].rt1, vecs[i].d1, vecs[i].we2, vecs[i].rt2, vecs[i].d2);
      if (vecs[i].we1 && vecs[i].we2 && vecs[i].rt1 == vecs[i].rt2 && coll_model != 16'hFFFF)
        coll_model = coll_model + 16'd1;
      e.we1 = vecs[i].exp_we1; e.a1 = vecs[i].rt1; e.d1 = vecs[i].d1;
      e.we2 = vecs[i].exp_we2; e.a2 = vecs[i].rt2; e.d2 = vecs[i].d2;
      e.coll = coll_model;
      exp_q.push_back(e);
      tick();
      pop_check(i);
    end
    idle_inputs();
    tick();

    // Scoreboard lifecycle for r9
    set_chk(1, 7'd9); set_chk(2, 7'd10);
    bus.issue_valid_in1 = 1'b1; bus.issue_rt_in1 = 7'd9;
    tick();
    idle_inputs();
    check("life_busy_set", {127'd0, bus.chk_busy_out[1]}, 128'd1);
    check("life_other_idle", {127'd0, bus.chk_busy_out[2]}, 128'd0);
    tick(); tick();
    check("life_busy_hold", {127'd0, bus.chk_busy_out[1]}, 128'd1);
    retire(1'b1, 7'd9, 128'hC0FFEE, 1'b0, 7'd0, 128'd0);
    tick();
    idle_inputs();
    check("life_rf_we1", {127'd0, bus.rf_we_out1}, 128'd1);
    check("life_rf_waddr1", {121'd0, bus.rf_waddr_out1}, 128'd9);
    check("life_busy_wcyc", {127'd0, bus.chk_busy_out[1]}, {127'd0, !fwd_on});
    tick();
    check("life_busy_clr", {127'd0, bus.chk_busy_out[1]}, 128'd0);

    // Both pipes issue the same rt; one retire clears it
    bus.issue_valid_in1 = 1'b1; bus.issue_rt_in1 = 7'd9;
    bus.issue_valid_in2 = 1'b1; bus.issue_rt_in2 = 7'd9;
    tick();
    idle_inputs();
    check("dual_issue_busy", {127'd0, bus.chk_busy_out[1]}, 128'd1);
    retire(1'b0, 7'd0, 128'd0, 1'b1, 7'd9, 128'h99);
    tick();
    idle_inputs();
    tick();
    check("dual_issue_clr", {127'd0, bus.chk_busy_out[1]}, 128'd0);

    // Same-edge set and clear of r12: set wins
    set_chk(0, 7'd12);
    bus.issue_valid_in2 = 1'b1; bus.issue_rt_in2 = 7'd12;
    tick();
    idle_inputs();
    check("race_busy_set", {127'd0, bus.chk_busy_out[0]}, 128'd1);
    retire(1'b0, 7'd0, 128'd0, 1'b1, 7'd12, 128'h12);
    tick();
    idle_inputs();
    bus.issue_valid_in1 = 1'b1; bus.issue_rt_in1 = 7'd12;
    tick();
    idle_inputs();
    check("race_set_wins", {127'd0, bus.chk_busy_out[0]}, 128'd1);
    tick();
    check("race_still_busy", {127'd0, bus.chk_busy_out[0]}, 128'd1);
    retire(1'b1, 7'd12, 128'h13, 1'b0, 7'd0, 128'd0);
    tick();
    idle_inputs();
    tick();
    check("race_final_clr", {127'd0, bus.chk_busy_out[0]}, 128'd0);

`ifdef SPU_WB_FORWARD_EN
    // Forwarding from both rf write ports
    set_chk(0, 7'd7); set_chk(1, 7'd8); set_chk(2, 7'd100); set_chk(3, 7'd101);
    bus.issue_valid_in1 = 1'b1; bus.issue_rt_in1 = 7'd7;
    bus.issue_valid_in2 = 1'b1; bus.issue_rt_in2 = 7'd8;
    tick();
    idle_inputs();
    retire(1'b1, 7'd7, {4{32'h0707_ABCD}}, 1'b1, 7'd8, {4{32'h0808_1234}});
    tick();
    idle_inputs();
    check("fwd_hit", {124'd0, bus.fwd_hit_out}, 128'h3);
    check("fwd_data0", bus.fwd_data_out[0 +: 128], {4{32'h0707_ABCD}});
    check("fwd_data1", bus.fwd_data_out[128 +: 128], {4{32'h0808_1234}});
    check("fwd_busy", {124'd0, bus.chk_busy_out}, 128'd0);
    tick();
    check("fwd_hit_after", {124'd0, bus.fwd_hit_out}, 128'd0);
    bus.chk_reg_in = '0;
`endif

    // Latency errors are sticky and capture the first unit
    retire(1'b0, 7'd0, 128'd0, 1'b1, 7'd40, 128'h40);
    bus.latency_in2 = 3'd2; bus.unitID_in2 = 3'd3;
    tick();
    idle_inputs();
    check("lerr_no_write", {127'd0, bus.rf_we_out2}, 128'd0);
    check("lerr_flag", {127'd0, bus.latency_err_out}, 128'd1);
    check("lerr_unit", {125'd0, bus.err_unit_out}, 128'd3);
    retire(1'b1, 7'd41, 128'h41, 1'b1, 7'd42, 128'h42);
    bus.latency_in1 = 3'd1; bus.unitID_in1 = 3'd5;
    bus.latency_in2 = 3'd4; bus.unitID_in2 = 3'd1;
    tick();
    idle_inputs();
    check("lerr_sticky_unit", {125'd0, bus.err_unit_out}, 128'd3);
    check("lerr_sticky_we", {126'd0, bus.rf_we_out1, bus.rf_we_out2}, 128'd0);

    // Asynchronous reset mid-stream
    set_chk(3, 7'd30);
    bus.issue_valid_in1 = 1'b1; bus.issue_rt_in1 = 7'd30;
    tick();
    idle_inputs();
    check("pre_rst_busy", {127'd0, bus.chk_busy_out[3]}, 128'd1);
    retire(1'b1, 7'd50, 128'h50, 1'b0, 7'd0, 128'd0);
    #2;
    reset = 1'b0;
    #1;
    check("arst_lerr", {127'd0, bus.latency_err_out}, 128'd0);
    check("arst_eunit", {125'd0, bus.err_unit_out}, 128'd0);
    check("arst_coll", {112'd0, bus.collision_count_out}, 128'd0);
    check("arst_busy", {124'd0, bus.chk_busy_out}, 128'd0);
    tick();
    check("arst_drop_write", {127'd0, bus.rf_we_out1}, 128'd0);
    idle_inputs();
    reset = 1'b1;
    coll_model = 16'd0;
    tick();

    // Simultaneous latency errors report pipe 1
    retire(1'b1, 7'd60, 128'h60, 1'b1, 7'd61, 128'h61);
    bus.latency_in1 = 3'd7; bus.unitID_in1 = 3'd6;
    bus.latency_in2 = 3'd1; bus.unitID_in2 = 3'd2;
    tick();
    idle_inputs();
    check("lerr_both_unit", {125'd0, bus.err_unit_out}, 128'd6);

    // Collision saturation
    retire(1'b1, 7'd20, 128'h1, 1'b1, 7'd20, 128'h2);
    tick();
    coll_model = coll_model + 16'd1;
    check("coll_we1", {127'd0, bus.rf_we_out1}, 128'd0);
    check("coll_we2", {127'd0, bus.rf_we_out2}, 128'd1);
    check("coll_data2", bus.rf_wdata_out2, 128'h2);
    check("coll_first", {112'd0, bus.collision_count_out}, {112'd0, coll_model});
    for (int i = 1; i < 70000; i++) begin
      tick();
      if (coll_model != 16'hFFFF) coll_model = coll_model + 16'd1;
    end
    check("coll_sat", {112'd0, bus.collision_count_out}, 128'hFFFF);
    check("coll_model_sat", {112'd0, bus.collision_count_out}, {112'd0, coll_model});
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
